// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and forward-select encodings for the multi-cycle hazard unit
package hazard_pkg;

    typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_DONE} mem_state_e;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
        return hit_m ? FWD_M : hit_w ? FWD_W : FWD_RF;
    endfunction

endpackage

// File: rtl/mdu_busy_ctr.sv
// mdu_busy_ctr: iterative mult/div busy counter
//   clk, reset_n : clock, async active-low reset
//   load         : start accepted this cycle, counter loads MDU_LAT
//   busy         : counter non-zero, MDU still iterating
module mdu_busy_ctr #(
    parameter int MDU_LAT = 32
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic busy
);
    logic [5:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (load)
            cnt <= 6'(MDU_LAT);
        else if (cnt != '0)
            cnt <= cnt - 6'd1;
    end

    assign busy = cnt != '0;

endmodule

// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: forwarding, stall/flush control with memory wait-states, MDU busy and stall counter
//   inputs : D/E/M/W register specifiers, write/load/branch flags, MemReqM, MdStartE, MdReadD
//   outputs: ForwardA/B D/E selects, Stall F/D/E/M, Flush E/M/W, MdBusy, StallCycles
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REGW    = 5,
    parameter int MEM_LAT = 2,
    parameter int MDU_LAT = 32,
    parameter int CNTW    = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [REGW-1:0] rsD,
    input  logic [REGW-1:0] rtD,
    input  logic [REGW-1:0] rsE,
    input  logic [REGW-1:0] rtE,
    input  logic [REGW-1:0] WriteRegE,
    input  logic [REGW-1:0] WriteRegM,
    input  logic [REGW-1:0] WriteRegW,
    input  logic            RegWriteE,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    input  logic            MemtoRegE,
    input  logic            MemtoRegM,
    input  logic            BranchD,
    input  logic            MemReqM,
    input  logic            MdStartE,
    input  logic            MdReadD,
    output logic            ForwardAD,
    output logic            ForwardBD,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic            StallF,
    output logic            StallD,
    output logic            StallE,
    output logic            StallM,
    output logic            FlushE,
    output logic            FlushM,
    output logic            FlushW,
    output logic            MdBusy,
    output logic [CNTW-1:0] StallCycles
);
    localparam logic [3:0] WINIT = 4'(MEM_LAT > 0 ? MEM_LAT - 1 : 0);

    mem_state_e state, state_nxt;
    logic [3:0] wcnt, wcnt_nxt;
    logic memstall, lwstall, branchstall, mdrdstall, mdstruct, dstall;

    // a source matches a producer only when it writes and is not the zero register
    function automatic logic hit(input logic [REGW-1:0] src, input logic [REGW-1:0] dst, input logic we);
        return we && src != '0 && src == dst;
    endfunction

    assign ForwardAE = fwd_sel(hit(rsE, WriteRegM, RegWriteM), hit(rsE, WriteRegW, RegWriteW));
    assign ForwardBE = fwd_sel(hit(rtE, WriteRegM, RegWriteM), hit(rtE, WriteRegW, RegWriteW));
    assign ForwardAD = hit(rsD, WriteRegM, RegWriteM);
    assign ForwardBD = hit(rtD, WriteRegM, RegWriteM);

    assign lwstall     = MemtoRegE && rtE != '0 && (rsD == rtE || rtD == rtE);
    assign branchstall = BranchD && (hit(rsD, WriteRegE, RegWriteE) || hit(rtD, WriteRegE, RegWriteE) ||
                                     hit(rsD, WriteRegM, MemtoRegM) || hit(rtD, WriteRegM, MemtoRegM));
    assign mdrdstall   = MdReadD && (MdBusy || MdStartE);
    assign mdstruct    = MdStartE && MdBusy;
    assign dstall      = lwstall || branchstall || mdrdstall;

    // priority: memory wait freezes everything up to M, MDU conflict holds up to E, D hazards hold F/D
    assign StallM = memstall;
    assign FlushW = memstall;
    assign StallE = memstall || mdstruct;
    assign StallF = StallE || dstall;
    assign StallD = StallF;
    assign FlushM = !memstall && mdstruct;
    assign FlushE = !memstall && !mdstruct && dstall;

    // DONE ignores MemReqM because the same instruction is still leaving M
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        memstall  = 1'b0;
        case (state)
            MEM_IDLE: if (MemReqM && MEM_LAT != 0) begin
                memstall  = 1'b1;
                wcnt_nxt  = WINIT;
                state_nxt = (MEM_LAT == 1) ? MEM_DONE : MEM_WAIT;
            end
            MEM_WAIT: begin
                memstall  = 1'b1;
                wcnt_nxt  = wcnt - 4'd1;
                state_nxt = (wcnt == 4'd1) ? MEM_DONE : MEM_WAIT;
            end
            default: state_nxt = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= MEM_IDLE;
            wcnt        <= '0;
            StallCycles <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (StallF && !(&StallCycles))
                StallCycles <= StallCycles + 1'b1;
        end
    end

    mdu_busy_ctr #(.MDU_LAT(MDU_LAT)) u_mdu (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (MdStartE && !StallE && !MdBusy),
        .busy   (MdBusy)
    );

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc: directed self-checking bench for hazard_unit_mc (MEM_LAT=3, MDU_LAT=4, CNTW=4)
module tb_hazard_unit_mc;
    logic       clk, reset_n;
    logic [4:0] rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, MemReqM, MdStartE, MdReadD;
    logic       ForwardAD, ForwardBD, StallF, StallD, StallE, StallM, FlushE, FlushM, FlushW, MdBusy;
    logic [1:0] ForwardAE, ForwardBE;
    logic [3:0] StallCycles;
    int         n_tests = 0;
    int         n_fail  = 0;

    hazard_unit_mc #(.REGW(5), .MEM_LAT(3), .MDU_LAT(4), .CNTW(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
        .MemReqM(MemReqM), .MdStartE(MdStartE), .MdReadD(MdReadD),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .MdBusy(MdBusy), .StallCycles(StallCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        {rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW} = '0;
        {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, MemReqM, MdStartE, MdReadD} = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        clr();
        #3;
        chk("rst_sc", 32'(StallCycles), 0);
        chk("rst_busy", 32'(MdBusy), 0);
        chk("rst_stallf", 32'(StallF), 0);
        tick();
        reset_n = 1'b1;

        rsE = 3; rtE = 3; rsD = 3; WriteRegM = 3; RegWriteM = 1; WriteRegW = 3; RegWriteW = 1;
        #1;
        chk("fwd_ae_m", 32'(ForwardAE), 2);
        chk("fwd_be_m", 32'(ForwardBE), 2);
        chk("fwd_ad", 32'(ForwardAD), 1);
        chk("fwd_bd_r0", 32'(ForwardBD), 0);
        chk("fwd_nostall", 32'(StallF), 0);
        RegWriteM = 0;
        #1;
        chk("fwd_ae_w", 32'(ForwardAE), 1);
        chk("fwd_ad_off", 32'(ForwardAD), 0);
        RegWriteM = 1; rsE = 0;
        #1;
        chk("fwd_ae_r0", 32'(ForwardAE), 0);
        clr();
        tick();

        MemtoRegE = 1; rtE = 5; rsD = 5;
        #1;
        chk("lw_stallf", 32'(StallF), 1);
        chk("lw_stalld", 32'(StallD), 1);
        chk("lw_flushe", 32'(FlushE), 1);
        chk("lw_stalle", 32'(StallE), 0);
        chk("lw_flushm", 32'(FlushM), 0);
        tick();
        clr();
        #1;
        chk("lw_sc", 32'(StallCycles), 1);
        chk("lw_clear", 32'(StallF), 0);
        MemtoRegE = 1; rtE = 0; rsD = 0;
        #1;
        chk("lw_r0", 32'(StallF), 0);
        clr();
        BranchD = 1; RegWriteE = 1; WriteRegE = 7; rtD = 7;
        #1;
        chk("br_e", 32'(FlushE), 1);
        clr();
        tick();
        BranchD = 1; MemtoRegM = 1; WriteRegM = 9; rsD = 9;
        #1;
        chk("br_m", 32'(FlushE), 1);
        clr();
        tick();

        MemReqM = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("mem_stallm", 32'(StallM), 32'((i % 4) != 3));
            chk("mem_flushw", 32'(FlushW), 32'((i % 4) != 3));
            chk("mem_stallf", 32'(StallF), 32'((i % 4) != 3));
            tick();
        end
        MemReqM = 0;
        #1;
        chk("mem_sc", 32'(StallCycles), 7);
        chk("mem_idle", 32'(StallM), 0);

        MemtoRegE = 1; rtE = 5; rsD = 5; MemReqM = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cc_flushe", 32'(FlushE), 32'(i == 3));
            chk("cc_stallm", 32'(StallM), 32'(i != 3));
            chk("cc_stalld", 32'(StallD), 1);
            tick();
        end
        clr();
        #1;
        chk("cc_sc", 32'(StallCycles), 11);
        chk("cc_clear", 32'(FlushE), 0);

        MdStartE = 1;
        #1;
        chk("md_start_idle", 32'(MdBusy), 0);
        chk("md_start_stalle", 32'(StallE), 0);
        tick();
        MdStartE = 0; MdReadD = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("md_busy", 32'(MdBusy), 32'(i < 4));
            chk("md_rd_flushe", 32'(FlushE), 32'(i < 4));
            tick();
        end
        clr();
        #1;
        chk("md_sc", 32'(StallCycles), 15);

        MdStartE = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("ms_busy", 32'(MdBusy), 32'(i < 4));
            chk("ms_flushm", 32'(FlushM), 32'(i < 4));
            chk("ms_stalle", 32'(StallE), 32'(i < 4));
            if (i < 4) tick();
        end
        chk("sat_sc", 32'(StallCycles), 15);
        tick();
        MdStartE = 0; MemReqM = 1;
        #1;
        chk("ar_busy_pre", 32'(MdBusy), 1);
        chk("ar_stallm_pre", 32'(StallM), 1);
        tick();
        MemReqM = 0;
        #1;
        chk("ar_wait_hold", 32'(StallM), 1);
        reset_n = 1'b0;
        #1;
        chk("ar_stallm", 32'(StallM), 0);
        chk("ar_busy", 32'(MdBusy), 0);
        chk("ar_sc", 32'(StallCycles), 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_stallm", 32'(StallM), 0);
        chk("post_busy", 32'(MdBusy), 0);
        chk("post_sc", 32'(StallCycles), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Parametrised multi-cycle hazard controller for the 5-stage pipelined MIPS core. It replaces the purely combinational hazard unit: same E/D-stage forwarding and load-use/branch stall rules, plus a wait-state FSM for variable-latency data memory, a busy counter for an iterative multiply/divide unit (HI/LO), and a saturating stall-cycle performance counter. It sits beside the datapath and drives every pipeline-register enable and flush.

## Interface
Parameters:
- REGW, 5, register-specifier width (register file holds 2**REGW regs; reg 0 is hardwired zero)
- MEM_LAT, 2, data-memory wait cycles per load/store in M (0..15; 0 = single-cycle memory)
- MDU_LAT, 32, multiply/divide busy cycles (1..63)
- CNTW, 16, stall-counter width

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous, active-low reset
- rsD, rtD, rsE, rtE  in  REGW  source specifiers
- WriteRegE, WriteRegM, WriteRegW  in  REGW  destination specifiers
- RegWriteE, RegWriteM, RegWriteW  in  1  destination-write valid
- MemtoRegE, MemtoRegM  in  1  load in stage
- BranchD  in  1  branch in D
- MemReqM  in  1  load/store in M
- MdStartE  in  1  mult/div in E
- MdReadD  in  1  mfhi/mflo in D
- ForwardAD, ForwardBD  out  1  D-stage comparator forward from M
- ForwardAE, ForwardBE  out  2  ALU forward: 10 = M, 01 = W, 00 = regfile
- StallF, StallD, StallE, StallM  out  1  hold stage register
- FlushE, FlushM, FlushW  out  1  bubble into stage register
- MdBusy  out  1  MDU iterating
- StallCycles  out  CNTW  cycles with StallF high, saturating

## Operation
- Forwarding (combinational): AE/BE prefer M over W; never forward reg 0. AD/BD set when D source equals WriteRegM, is non-zero, and RegWriteM.
- lwstall = MemtoRegE & rtE!=0 & (rsD==rtE | rtD==rtE).
- branchstall = BranchD & ((RegWriteE & WriteRegE!=0 & WriteRegE∈{rsD,rtD}) | (MemtoRegM & WriteRegM!=0 & WriteRegM∈{rsD,rtD})).
- mdrdstall = MdReadD & (MdBusy | MdStartE).
- mdstruct = MdStartE & MdBusy.
- Memory FSM states MEM_IDLE, MEM_WAIT, MEM_DONE; 4-bit down-counter wcnt.
  - IDLE: if MemReqM & MEM_LAT!=0 → memstall=1, wcnt←MEM_LAT-1, go WAIT (or DONE if MEM_LAT==1).
  - WAIT: memstall=1; wcnt decrements; at wcnt==1 go DONE.
  - DONE: memstall=0, MemReqM ignored (same instruction leaving M); go IDLE.
  - Net: memstall high exactly MEM_LAT consecutive cycles per memory op.
- MDU counter mcnt (6 bits): loads MDU_LAT when MdStartE & !StallE & !MdBusy; decrements to 0. MdBusy = mcnt!=0.
- Output priority (highest first):
  1. memstall: StallF/D/E/M=1, FlushW=1, all others 0.
  2. mdstruct: StallF/D/E=1, FlushM=1.
  3. lwstall | branchstall | mdrdstall: StallF/D=1, FlushE=1.
  4. Otherwise all stall/flush outputs 0.
- StallCycles increments on every cycle with StallF=1 and holds at all-ones.

## Timing
- Reset (async, reset_n low): FSM=MEM_IDLE, wcnt=0, mcnt=0, StallCycles=0.
  - Registered outputs reset to 0.
  - Combinational outputs follow inputs, with FSM/counter terms at their reset values.
- Release is synchronous to the next clk rising edge.
- Forward/stall/flush outputs are combinational from inputs plus current state: zero-cycle latency.
- MdStartE accepted at edge t → MdBusy high for cycles t+1 .. t+MDU_LAT.
- MdStartE held while StallE=1 does not reload mcnt.
- Reset asserted mid-wait or mid-MDU: aborts immediately; no residual stall after release.
- Memory op in M in the cycle after DONE starts a fresh wait (back-to-back loads each pay MEM_LAT).

## Structure
- Package hazard_pkg:
  - mem_state_e enum (MEM_IDLE, MEM_WAIT, MEM_DONE)
  - forward-select constants FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10
- Sub-module mdu_busy_ctr (load/decrement counter with busy flag), parametrised by MDU_LAT.
- Forwarding, stall/flush priority logic, memory FSM and StallCycles stay in the top module.

## Test plan
- rsE=3, WriteRegM=3, RegWriteM=1, WriteRegW=3, RegWriteW=1 → ForwardAE=10; same with rsE=0 → 00.
- MemtoRegE=1, rtE=5, rsD=5 → StallF=StallD=FlushE=1 for one cycle; StallCycles +1.
- MEM_LAT=3, MemReqM held high → StallM and FlushW high for exactly 3 cycles, low in DONE; second op immediately after → another 3 cycles.
- MDU_LAT=4: MdStartE one cycle, then MdReadD → FlushE for 4 cycles until MdBusy drops; MdStartE during busy → FlushM=1, StallE=1.
- memstall concurrent with lwstall → only memstall pattern visible (FlushE=0); lwstall resolves after wait.
- reset_n low during MEM_WAIT and MdBusy → all state 0 asynchronously; StallCycles saturates at 2**CNTW-1 under continuous stall (CNTW=4 run).
